dataflow_fifo: RTL and testbench

- Elastic buffer on a valid/ready dataflow edge, placed directly downstream of a combinational arithmetic operator such as signed remainder.
- Consumes the operator's result stream and re-times it.
- Breaks the combinational valid/data path and the ready path between the operator and its consumer.
- Holds up to DEPTH tokens.
- Optionally forwards a token in the same cycle when empty (BYPASS).

---
 rtl/dataflow_pkg.sv | 15 +
 rtl/dataflow_fifo_mem.sv | 29 ++
 rtl/dataflow_fifo.sv | 101 ++++++++++
 tb/tb_dataflow_fifo.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/dataflow_pkg.sv
// Shared sizing helpers for the dataflow elastic buffer and its storage.
// Pure constant functions; no logic, no latency, no flow control.
// Imported by every dataflow_fifo file so pointer/count widths agree.
package dataflow_pkg;

    // An index needs at least one bit even when DEPTH is 1.
    function automatic int ptr_width(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dataflow_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one async read port.
// Latency: written data readable the cycle after the write edge.
// Backpressure: none; the caller only writes free entries.
module dataflow_fifo_mem
    import dataflow_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          wr_en,
    input  logic [ptr_width(DEPTH)-1:0]   wr_addr,
    input  logic [WIDTH-1:0]              wr_data,
    input  logic [ptr_width(DEPTH)-1:0]   rd_addr,
    output logic [WIDTH-1:0]              rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Contents are deliberately not reset so this can become a RAM macro.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/dataflow_fifo.sv
// Elastic valid/ready buffer re-timing an arithmetic operator's result stream.
// Latency: 1 cycle minimum; 0 cycles when BYPASS=1 and the buffer is empty.
// Backpressure: in_ready depends only on occupancy, never on out_ready.
module dataflow_fifo
    import dataflow_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 2,
    parameter int BYPASS = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [WIDTH-1:0]                in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [WIDTH-1:0]                out_data,
    output logic [count_width(DEPTH)-1:0]   count
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = count_width(DEPTH);

    if (DEPTH < 1 || (BYPASS != 0 && BYPASS != 1)) begin : g_param_check
        $error("dataflow_fifo: DEPTH must be >= 1 and BYPASS must be 0 or 1");
    end

    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full, empty;
    logic             push, pop, bypass, store, drain;
    logic [WIDTH-1:0] rd_data;

    // Explicit wrap keeps non-power-of-two depths correct.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign in_ready  = !rst && !full;
    assign out_valid = !rst && (!empty || (BYPASS == 1 && in_valid));
    assign out_data  = empty ? in_data : rd_data;
    assign count     = count_q;

    assign push   = in_valid && in_ready;
    assign pop    = out_valid && out_ready;
    // A token consumed while empty went straight through and never touches storage.
    assign bypass = (BYPASS == 1) && empty && pop;
    assign store  = push && !bypass;
    assign drain  = pop && !empty;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (rst) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (store) tail_d = ptr_inc(tail_q);
            if (drain) head_d = ptr_inc(head_q);
            case ({store, drain})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        head_q  <= head_d;
        tail_q  <= tail_d;
        count_q <= count_d;
    end

    dataflow_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (store),
        .wr_addr (tail_q),
        .wr_data (in_data),
        .rd_addr (head_q),
        .rd_data (rd_data)
    );

    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        count_q <= CW'(DEPTH));

    a_stall_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready && !empty) |=> $stable(out_data));

    a_no_empty_pop: assert property (@(posedge clk) disable iff (rst)
        (pop && empty) |-> (BYPASS == 1));

endmodule

// File: tb/tb_dataflow_fifo.sv
// Randomized and directed bench for dataflow_fifo across several DEPTH/BYPASS points.
// A queue-per-instance model predicts every output each cycle.
module tb_dataflow_fifo;

    localparam int NI = 5;
    localparam int DEP [NI] = '{2, 3, 4, 2, 1};
    localparam int BYP [NI] = '{0, 0, 0, 1, 0};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iv   [NI];
    logic [15:0] id   [NI];
    logic        ordy [NI];
    logic        ir   [NI];
    logic        ov   [NI];
    logic [15:0] od   [NI];
    logic [2:0]  cnt  [NI];

    logic [15:0] q [NI][$];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int CWL = $clog2(DEP[g] + 1);
        logic [CWL-1:0] cnt_l;
        dataflow_fifo #(
            .WIDTH  (16),
            .DEPTH  (DEP[g]),
            .BYPASS (BYP[g])
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (iv[g]),
            .in_ready  (ir[g]),
            .in_data   (id[g]),
            .out_valid (ov[g]),
            .out_ready (ordy[g]),
            .out_data  (od[g]),
            .count     (cnt_l)
        );
        assign cnt[g] = 3'(cnt_l);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Compare all instances against the queue model, then apply this cycle's transfers.
    task automatic settle();
        #1;
        for (int i = 0; i < NI; i++) begin
            int sz;
            bit e_ir, e_ov, push, pop;
            sz   = q[i].size();
            e_ir = !rst && (sz < DEP[i]);
            e_ov = !rst && (sz > 0 || (BYP[i] == 1 && iv[i]));
            chk($sformatf("in_ready[%0d]", i), 32'(ir[i]), 32'(e_ir));
            chk($sformatf("out_valid[%0d]", i), 32'(ov[i]), 32'(e_ov));
            chk($sformatf("count[%0d]", i), 32'(cnt[i]), 32'(sz));
            if (e_ov)
                chk($sformatf("out_data[%0d]", i), 32'(od[i]), 32'(sz > 0 ? q[i][0] : id[i]));
            if (rst) begin
                q[i].delete();
            end else begin
                push = iv[i] && e_ir;
                pop  = e_ov && ordy[i];
                if (!(sz == 0 && push && pop)) begin
                    if (pop)  void'(q[i].pop_front());
                    if (push) q[i].push_back(id[i]);
                end
            end
        end
    endtask

    task automatic adv();
        @(negedge clk);
    endtask

    task automatic idle_all();
        for (int i = 0; i < NI; i++) begin
            iv[i] = 1'b0; id[i] = 16'h0; ordy[i] = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NI; i++) begin
            iv[i] = 1'b1; id[i] = 16'hDEAD; ordy[i] = 1'b1;
        end
        adv();
        // Reset held three cycles with a token offered everywhere.
        for (int c = 0; c < 3; c++) begin
            settle();
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("rst_in_ready[%0d]", i), 32'(ir[i]), 32'h0);
                chk($sformatf("rst_out_valid[%0d]", i), 32'(ov[i]), 32'h0);
                chk($sformatf("rst_count[%0d]", i), 32'(cnt[i]), 32'h0);
            end
            adv();
        end
        rst = 1'b0;
        idle_all();

        // First push after reset, one cycle of latency.
        iv[0] = 1'b1; id[0] = 16'h5; ordy[0] = 1'b1;
        settle(); chk("first_push_latency", 32'(ov[0]), 32'h0); adv();
        iv[0] = 1'b0;
        settle(); chk("first_out_valid", 32'(ov[0]), 32'h1); chk("first_out_data", 32'(od[0]), 32'h5); adv();

        // Fill to full, then offer a third token while out_ready rises.
        ordy[0] = 1'b0; iv[0] = 1'b1; id[0] = 16'h11;
        settle(); adv();
        id[0] = 16'h22;
        settle(); adv();
        id[0] = 16'h33; ordy[0] = 1'b1;
        settle();
        chk("full_count", 32'(cnt[0]), 32'h2);
        chk("full_in_ready", 32'(ir[0]), 32'h0);
        chk("full_out_data", 32'(od[0]), 32'h11);
        adv();
        iv[0] = 1'b0; ordy[0] = 1'b0;
        settle(); chk("after_full_count", 32'(cnt[0]), 32'h1); chk("after_full_data", 32'(od[0]), 32'h22); adv();
        ordy[0] = 1'b1;
        settle(); adv();
        ordy[0] = 1'b0;
        settle(); chk("no_third_token", 32'(ov[0]), 32'h0); chk("drained_count", 32'(cnt[0]), 32'h0); adv();

        // Continuous streaming of 1..100.
        iv[0] = 1'b1; ordy[0] = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            id[0] = 16'(k);
            settle();
            if (k >= 2) begin
                chk($sformatf("stream_data_%0d", k - 1), 32'(od[0]), 32'(k - 1));
                chk($sformatf("stream_count_%0d", k), 32'(cnt[0]), 32'h1);
            end
            adv();
        end
        iv[0] = 1'b0;
        settle(); chk("stream_last", 32'(od[0]), 32'd100); adv();
        ordy[0] = 1'b0;

        // Bypass on an empty buffer, then the same token stalled.
        iv[3] = 1'b1; id[3] = 16'hABCD; ordy[3] = 1'b1;
        settle();
        chk("bypass_out_valid", 32'(ov[3]), 32'h1);
        chk("bypass_out_data", 32'(od[3]), 32'hABCD);
        chk("bypass_count", 32'(cnt[3]), 32'h0);
        adv();
        iv[3] = 1'b0;
        settle(); chk("bypass_count_after", 32'(cnt[3]), 32'h0); chk("bypass_empty_after", 32'(ov[3]), 32'h0); adv();
        iv[3] = 1'b1; id[3] = 16'h1234; ordy[3] = 1'b0;
        settle(); chk("bypass_stall_view", 32'(od[3]), 32'h1234); adv();
        iv[3] = 1'b0;
        settle(); chk("bypass_stored_count", 32'(cnt[3]), 32'h1); chk("bypass_stored_data", 32'(od[3]), 32'h1234); adv();
        ordy[3] = 1'b1;
        settle(); adv();
        ordy[3] = 1'b0;

        // Reset mid-stream with three tokens held.
        iv[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            id[2] = 16'(16'hA + k);
            settle(); adv();
        end
        iv[2] = 1'b0;
        settle(); chk("mid_count_before", 32'(cnt[2]), 32'h3); chk("mid_head_before", 32'(od[2]), 32'hA); adv();
        rst = 1'b1;
        settle(); chk("mid_rst_out_valid", 32'(ov[2]), 32'h0); adv();
        rst = 1'b0;
        settle(); chk("mid_count_after", 32'(cnt[2]), 32'h0); chk("mid_out_valid_after", 32'(ov[2]), 32'h0); adv();
        ordy[2] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            settle(); chk($sformatf("mid_no_stale_%0d", c), 32'(ov[2]), 32'h0); adv();
        end

        // Random traffic on every configuration.
        for (int c = 0; c < 1000; c++) begin
            for (int i = 0; i < NI; i++) begin
                iv[i]   = ($urandom_range(0, 3) != 0);
                id[i]   = 16'($urandom);
                ordy[i] = ($urandom_range(0, 2) != 0);
            end
            settle(); adv();
        end
        for (int i = 0; i < NI; i++) begin
            iv[i] = 1'b0; ordy[i] = 1'b1;
        end
        for (int c = 0; c < 8; c++) begin
            settle(); adv();
        end
        for (int i = 0; i < NI; i++)
            chk($sformatf("final_empty[%0d]", i), 32'(cnt[i]), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
